// File: rtl/dmem_dbg_pkg.sv
// Shared types and constants for the debug/DMA memory initiator.
// One state encoding and the read-FIFO geometry used by both modules.
package dmem_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = 2;

endpackage

// File: rtl/dmem_dbg_rdfifo.sv
// Two-entry read-data FIFO between memory port B and the rd valid/ready output.
// Push and pop may occur in the same cycle; the caller never pushes when full.
module dmem_dbg_rdfifo
    import dmem_dbg_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [DATA_WIDTH-1:0] entry_q [FIFO_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            if (push) begin
                entry_q[wr_ptr] <= push_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = entry_q[rd_ptr];

endmodule

// File: rtl/dmem_dbg_master.sv
// Debug/DMA block-transfer initiator on port B of the dual-port data memory.
// Handshakes: a transfer happens on every rising edge where valid && ready; valid never waits on ready.
module dmem_dbg_master
    import dmem_dbg_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_din,
    input  logic [DATA_WIDTH-1:0]   mem_dout,
    output logic [1:0]              dbg_state
);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  inflight;

    logic                  accept;
    logic                  wr_beat;
    logic                  issue;
    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [FIFO_CNT_W-1:0] occupancy;

    assign accept   = (state == ST_IDLE) && cmd_valid;
    assign wr_beat  = (state == ST_WRITE) && (remaining != '0) && wr_valid;
    assign fifo_pop = (fifo_count != '0) && rd_ready;

    // Slots already claimed once this cycle's pop retires; lets a pop free room for a same-cycle issue.
    assign occupancy = fifo_count + {1'b0, inflight} - {1'b0, fifo_pop};
    assign issue     = (state == ST_READ) && (remaining != '0)
                       && (occupancy < FIFO_CNT_W'(FIFO_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0)  state_nxt = ST_DONE;
                    else if (cmd_write) state_nxt = ST_WRITE;
                    else                state_nxt = ST_READ;
                end
            end
            ST_WRITE: begin
                if (remaining == '0 || (wr_beat && remaining == LEN_WIDTH'(1))) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_READ: begin
                if (remaining == '0 && !inflight
                    && (fifo_count == '0 || (fifo_count == FIFO_CNT_W'(1) && fifo_pop))) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = rst_n && (state == ST_IDLE);
        busy      = rst_n && ((state != ST_IDLE) || cmd_valid);
        done      = (state == ST_DONE);
        wr_ready  = (state == ST_WRITE) && (remaining != '0);
        mem_en    = wr_beat || issue;
        mem_we    = wr_beat;
        mem_wstrb = wr_beat ? wr_strb : '0;
        mem_addr  = (wr_beat || issue) ? cur_addr : '0;
        mem_din   = wr_beat ? wr_data : '0;
        rd_valid  = (fifo_count != '0);
        rd_data   = (fifo_count != '0) ? fifo_head : '0;
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            if (accept) begin
                cur_addr  <= cmd_addr;
                remaining <= cmd_len;
            end else if (wr_beat || issue) begin
                cur_addr  <= cur_addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

    // Memory returns read data one cycle after issue; capture it then.
    dmem_dbg_rdfifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rdfifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (mem_dout),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule
